hex_loader: RTL

HEX_LOADER -- requirements
Module: hex_loader

---
 rtl/hex_loader_if.sv | 27 ++
 rtl/hex_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hex_loader_if.sv
// Character-stream input, memory-write output and load status of the hex image loader.
interface hex_loader_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 64
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport slave (
    input  in_data, in_valid, in_last, wr_ready,
    output in_ready, wr_addr, wr_data, wr_valid, cpu_hold, done, error
  );

  modport master (
    output in_data, in_valid, in_last, wr_ready,
    input  in_ready, wr_addr, wr_data, wr_valid, cpu_hold, done, error
  );
endinterface

// File: rtl/hex_loader.sv
// Parses an ASCII hex memory image ("@addr", data words, "#" comments) into memory writes
// and holds the downstream cpu in reset until the image has loaded cleanly.
module hex_loader #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  hex_loader_if.slave  bus
);
  localparam int unsigned ADDR_DIG = (ADDR_W + 3) / 4;
  localparam int unsigned DATA_DIG = DATA_W / 4;
  localparam int unsigned MAX_DIG  = (DATA_DIG > ADDR_DIG) ? DATA_DIG : ADDR_DIG;
  localparam int unsigned ACC_W    = 4 * MAX_DIG;
  localparam int unsigned CNT_W    = $clog2(MAX_DIG + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_DATA, ST_COMMENT, ST_WRITE, ST_DONE, ST_ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  dig;
  logic              last_pend;
  logic              rdy;
  logic              wr_valid;
  logic              done;
  logic              error;
  logic              hold;

  logic              is_hex_c, is_sep_c, is_at_c, is_hash_c, is_lf_c, take_c;
  logic [3:0]        nib_c;
  logic [ACC_W-1:0]  acc_shift_c;

  // Character classification of the current input byte.
  always_comb begin
    is_hex_c = 1'b0;
    nib_c    = 4'h0;
    if (bus.in_data >= 8'h30 && bus.in_data <= 8'h39) begin
      is_hex_c = 1'b1;
      nib_c    = 4'(bus.in_data - 8'h30);
    end else if (bus.in_data >= 8'h61 && bus.in_data <= 8'h66) begin
      is_hex_c = 1'b1;
      nib_c    = 4'(bus.in_data - 8'h57);
    end else if (bus.in_data >= 8'h41 && bus.in_data <= 8'h46) begin
      is_hex_c = 1'b1;
      nib_c    = 4'(bus.in_data - 8'h37);
    end
    is_lf_c     = (bus.in_data == 8'h0A);
    is_sep_c    = (bus.in_data == 8'h20) || (bus.in_data == 8'h09) ||
                  (bus.in_data == 8'h0D) || is_lf_c;
    is_at_c     = (bus.in_data == 8'h40);
    is_hash_c   = (bus.in_data == 8'h23);
    take_c      = bus.in_valid & rdy;
    acc_shift_c = {acc[ACC_W-5:0], nib_c};
  end

  // Parser FSM; every status output changes on the same edge as the state it reflects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      acc       <= '0;
      dig       <= '0;
      last_pend <= 1'b0;
      rdy       <= 1'b0;
      wr_valid  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      hold      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          rdy <= 1'b1;
          if (take_c) begin
            if (is_hex_c) begin
              acc <= ACC_W'(nib_c);
              dig <= CNT_W'(1);
              if (bus.in_last) begin
                state <= ST_WRITE; rdy <= 1'b0; wr_valid <= 1'b1; last_pend <= 1'b1;
              end else begin
                state <= ST_DATA;
              end
            end else if (is_at_c && !bus.in_last) begin
              acc   <= '0;
              dig   <= '0;
              state <= ST_ADDR;
            end else if (is_hash_c || is_sep_c) begin
              if (bus.in_last) begin
                state <= ST_DONE; rdy <= 1'b0; done <= 1'b1; hold <= 1'b0;
              end else if (is_hash_c) begin
                state <= ST_COMMENT;
              end
            end else begin
              state <= ST_ERROR; rdy <= 1'b0; error <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (take_c) begin
            // An address token may never end the image, and may not be empty or too long.
            if (bus.in_last || !(is_hex_c || is_sep_c) ||
                (is_hex_c && dig == CNT_W'(ADDR_DIG)) || (is_sep_c && dig == '0)) begin
              state <= ST_ERROR; rdy <= 1'b0; error <= 1'b1;
            end else if (is_hex_c) begin
              acc <= acc_shift_c;
              dig <= dig + CNT_W'(1);
            end else begin
              addr  <= acc[ADDR_W-1:0];
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (take_c) begin
            if ((is_hex_c && dig == CNT_W'(DATA_DIG)) || !(is_hex_c || is_sep_c)) begin
              state <= ST_ERROR; rdy <= 1'b0; error <= 1'b1;
            end else if (is_hex_c) begin
              acc <= acc_shift_c;
              dig <= dig + CNT_W'(1);
              if (bus.in_last) begin
                state <= ST_WRITE; rdy <= 1'b0; wr_valid <= 1'b1; last_pend <= 1'b1;
              end
            end else begin
              state <= ST_WRITE; rdy <= 1'b0; wr_valid <= 1'b1; last_pend <= bus.in_last;
            end
          end
        end
        ST_COMMENT: begin
          if (take_c) begin
            if (bus.in_last) begin
              state <= ST_DONE; rdy <= 1'b0; done <= 1'b1; hold <= 1'b0;
            end else if (is_lf_c) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          if (bus.wr_ready) begin
            addr     <= addr + ADDR_W'(1);
            wr_valid <= 1'b0;
            if (last_pend) begin
              state <= ST_DONE; done <= 1'b1; hold <= 1'b0;
            end else begin
              state <= ST_IDLE; rdy <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
        end
        default: begin
          state <= ST_ERROR; rdy <= 1'b0; wr_valid <= 1'b0; error <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = rdy;
  assign bus.wr_addr  = addr;
  assign bus.wr_data  = acc[DATA_W-1:0];
  assign bus.wr_valid = wr_valid;
  assign bus.cpu_hold = hold;
  assign bus.done     = done;
  assign bus.error    = error;
endmodule
